// File: rtl/text_render_pkg.sv
// text_render_pkg: shared font geometry, font-size encodings and the 16-entry palette.
`default_nettype none

package text_render_pkg;

   localparam int FONT_W = 8;
   localparam int FONT_H = 16;
   localparam int ROM_AW = 11;

   typedef enum logic [1:0] {
      FS_OFF = 2'd0,
      FS_X1  = 2'd1,
      FS_X2  = 2'd2,
      FS_X4  = 2'd3
   } font_size_t;

   localparam logic [11:0] PALETTE [16] = '{
      12'h000, 12'h00A, 12'h0F0, 12'h0AA,
      12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
      12'h555, 12'h55F, 12'h5F5, 12'h5FF,
      12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
   };

endpackage

`default_nettype wire

// File: rtl/text_pixel_renderer_font_rom.sv
// font_rom_8x16: 2048x8 synchronous-read glyph ROM, IBM VGA 8x16 shapes, char 0 blank.
`default_nettype none

module font_rom_8x16
   import text_render_pkg::*;
(
   input  logic              clk,
   input  logic              en,
   input  logic [ROM_AW-1:0] addr,
   output logic [7:0]        data
);

   // Only the glyphs the clock overlay emits are populated; every other code is blank.
   function automatic logic [127:0] glyph(input logic [6:0] code);
      case (code)
         7'h01:   glyph = 128'h0000_7E81_A581_81BD_9981_817E_0000_0000;
         7'h30:   glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
         7'h31:   glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
         7'h32:   glyph = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
         7'h33:   glyph = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
         7'h34:   glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
         7'h35:   glyph = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
         7'h36:   glyph = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
         7'h37:   glyph = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
         7'h38:   glyph = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
         7'h39:   glyph = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
         7'h3A:   glyph = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
         default: glyph = '0;
      endcase
   endfunction

   logic [127:0] glyph_bits;
   assign glyph_bits = glyph(addr[10:4]);

   // Row 0 lives in the top byte, so ~row picks the byte offset.
   always_ff @(posedge clk) begin
      if (en) begin
         data <= glyph_bits[{~addr[3:0], 3'b000} +: 8];
      end
   end

endmodule

`default_nettype wire

// File: rtl/text_pixel_renderer.sv
// text_pixel_renderer: 2-tick font/palette pipeline producing registered RGB and co-aligned syncs.
// Optional blinking of palette index 15 is enabled by defining TEXT_BLINK_EN.
`default_nettype none

module text_pixel_renderer
   import text_render_pkg::*;
#(
   parameter logic [11:0] BG_COLOR     = 12'h000,
   parameter int          PIPE_DEPTH   = 2,
   parameter int          BLINK_FRAMES = 30
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              pixel_tick,
   input  logic              video_on,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [9:0]        pixelx,
   input  logic [ROM_AW-1:0] rom_addr,
   input  logic [1:0]        font_size,
   input  logic [3:0]        color_addr,
   output logic [11:0]       rgb,
   output logic              hsync,
   output logic              vsync,
   output logic              video_on_out
);

   logic [7:0] rom_data;
   logic [2:0] col_sel;
   logic [2:0] col_s1;
   logic [3:0] color_s1;
   logic       text_en_s1;
   logic       video_s1;
   logic       hsync_s1;
   logic       vsync_s1;
   logic       glyph_bit;
   logic       blink_ok;
   logic       unused_cfg;

   assign unused_cfg = ^{pixelx[9:5], 32'(PIPE_DEPTH), 32'(BLINK_FRAMES)};

   font_rom_8x16 u_font_rom (
      .clk  (clk),
      .en   (pixel_tick),
      .addr (rom_addr),
      .data (rom_data)
   );

   always_comb begin
      col_sel = 3'd0;
      case (font_size_t'(font_size))
         FS_X1:   col_sel = pixelx[2:0];
         FS_X2:   col_sel = pixelx[3:1];
         FS_X4:   col_sel = pixelx[4:2];
         default: col_sel = 3'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_s1     <= 3'd0;
         color_s1   <= 4'd0;
         text_en_s1 <= 1'b0;
         video_s1   <= 1'b0;
         hsync_s1   <= 1'b1;
         vsync_s1   <= 1'b1;
      end else if (pixel_tick) begin
         col_s1     <= col_sel;
         color_s1   <= color_addr;
         text_en_s1 <= (font_size != 2'd0);
         video_s1   <= video_on;
         hsync_s1   <= hsync_in;
         vsync_s1   <= vsync_in;
      end
   end

`ifdef TEXT_BLINK_EN
   localparam int CW = $clog2(BLINK_FRAMES + 1);
   logic [CW-1:0] frame_cnt;
   logic          blink_phase;
   logic          vsync_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
         vsync_prev  <= 1'b1;
      end else if (pixel_tick) begin
         vsync_prev <= vsync_in;
         if (vsync_prev && !vsync_in) begin
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   assign blink_ok = (color_s1 != 4'hF) || blink_phase;
`else
   assign blink_ok = 1'b1;
`endif

   // Bit 7 of the row word is the leftmost pixel.
   assign glyph_bit = rom_data[3'd7 - col_s1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb          <= 12'h000;
         hsync        <= 1'b1;
         vsync        <= 1'b1;
         video_on_out <= 1'b0;
      end else if (pixel_tick) begin
         if (!video_s1) begin
            rgb <= 12'h000;
         end else if (text_en_s1 && glyph_bit && blink_ok) begin
            rgb <= PALETTE[color_s1];
         end else begin
            rgb <= BG_COLOR;
         end
         hsync        <= hsync_s1;
         vsync        <= vsync_s1;
         video_on_out <= video_s1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_text_pixel_renderer.sv
// tb_text_pixel_renderer: directed self-checking bench for text_pixel_renderer.
`default_nettype none

module tb_text_pixel_renderer;

   localparam logic [11:0] BG  = 12'h123;
   localparam logic [11:0] GRN = 12'h0F0;
   localparam logic [11:0] WHT = 12'hFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        pixel_tick;
   logic        video_on;
   logic        hsync_in;
   logic        vsync_in;
   logic [9:0]  pixelx;
   logic [10:0] rom_addr;
   logic [1:0]  font_size;
   logic [3:0]  color_addr;
   logic [11:0] rgb;
   logic        hsync;
   logic        vsync;
   logic        video_on_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   text_pixel_renderer #(
      .BG_COLOR     (BG),
      .PIPE_DEPTH   (2),
      .BLINK_FRAMES (30)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pixel_tick   (pixel_tick),
      .video_on     (video_on),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .pixelx       (pixelx),
      .rom_addr     (rom_addr),
      .font_size    (font_size),
      .color_addr   (color_addr),
      .rgb          (rgb),
      .hsync        (hsync),
      .vsync        (vsync),
      .video_on_out (video_on_out)
   );

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Smiley row 3 is 8'b1000_0001 at 1x scale: only columns 0 and 7 are lit.
   function automatic logic [11:0] exp_px(input int x);
      return (x == 0 || x == 7) ? GRN : BG;
   endfunction

   initial begin
      int nframes;
      logic [11:0] e;

      reset = 1'b1; pixel_tick = 1'b0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      pixelx = '0; rom_addr = '0; font_size = 2'd0; color_addr = 4'd0;

      #3;
      check("rst_rgb", rgb, 12'h000);
      check("rst_hsync", 12'(hsync), 12'h001);
      check("rst_vsync", 12'(vsync), 12'h001);
      check("rst_video", 12'(video_on_out), 12'h000);

      // '0' row 5 = 8'hCE; pixelx 100 -> col 4 -> bit 3 = 1.
      @(negedge clk);
      reset = 1'b0;
      rom_addr = {7'h30, 4'h5}; pixelx = 10'd100; font_size = 2'd1; color_addr = 4'd2;
      video_on = 1'b1; hsync_in = 1'b0; pixel_tick = 1'b1;
      step(1);
      check("lat1_rgb", rgb, 12'h000);
      check("lat1_hsync", 12'(hsync), 12'h001);
      step(1);
      check("lat2_rgb", rgb, GRN);
      check("lat2_hsync", 12'(hsync), 12'h000);
      check("lat2_video", 12'(video_on_out), 12'h001);
      pixelx = 10'd98; hsync_in = 1'b1;
      step(1);
      check("pipe_rgb", rgb, GRN);
      check("pipe_hsync", 12'(hsync), 12'h000);
      step(1);
      check("col2_rgb", rgb, BG);
      check("col2_hsync", 12'(hsync), 12'h001);

      // 2x scaling over pixels 96..111 with row word 8'h81.
      rom_addr = {7'h01, 4'h3}; font_size = 2'd2;
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) pixelx = 10'(96 + i);
         step(1);
         if (i >= 1) begin
            e = (i - 1 <= 1 || i - 1 >= 14) ? GRN : BG;
            check($sformatf("x2_px%0d", 95 + i), rgb, e);
         end
      end

      font_size = 2'd0; pixelx = 10'd96;
      step(2);
      check("fs0_px96", rgb, BG);
      pixelx = 10'd110;
      step(2);
      check("fs0_px110", rgb, BG);

      video_on = 1'b0; font_size = 2'd1; pixelx = 10'd96; color_addr = 4'hF;
      step(2);
      check("blank_rgb", rgb, 12'h000);
      check("blank_video", 12'(video_on_out), 12'h000);

      video_on = 1'b1; rom_addr = {7'h00, 4'h3}; color_addr = 4'd2;
      step(2);
      check("char0_rgb", rgb, BG);

      // Stream pixels 0..7, stalling 5 clocks before pixel 4.
      rom_addr = {7'h01, 4'h3}; font_size = 2'd1;
      for (int i = 0; i <= 8; i++) begin
         if (i == 4) begin
            pixel_tick = 1'b0;
            for (int s = 0; s < 5; s++) begin
               pixelx = 10'd500; hsync_in = ~hsync_in; vsync_in = ~vsync_in; video_on = ~video_on;
               step(1);
               check($sformatf("stall%0d_rgb", s), rgb, exp_px(2));
               check($sformatf("stall%0d_hsync", s), 12'(hsync), 12'h000);
               check($sformatf("stall%0d_vsync", s), 12'(vsync), 12'h001);
            end
            video_on = 1'b1; vsync_in = 1'b1; pixel_tick = 1'b1;
         end
         if (i < 8) begin
            pixelx = 10'(i); hsync_in = (i % 2 == 1);
         end
         step(1);
         if (i >= 1) begin
            check($sformatf("strm_px%0d_rgb", i - 1), rgb, exp_px(i - 1));
            check($sformatf("strm_px%0d_hsync", i - 1), 12'(hsync), 12'((i - 1) % 2));
         end
      end

      // Mid-frame asynchronous reset.
      pixelx = 10'd0; hsync_in = 1'b0; vsync_in = 1'b0;
      step(2);
      check("pre_rst_rgb", rgb, GRN);
      check("pre_rst_vsync", 12'(vsync), 12'h000);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_rgb", rgb, 12'h000);
      check("mid_rst_hsync", 12'(hsync), 12'h001);
      check("mid_rst_vsync", 12'(vsync), 12'h001);
      check("mid_rst_video", 12'(video_on_out), 12'h000);
      vsync_in = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      step(1);
      check("post_rst1_rgb", rgb, 12'h000);
      step(1);
      check("post_rst2_rgb", rgb, GRN);

      // Palette index 15 on a lit pixel across frames.
      color_addr = 4'hF;
`ifdef TEXT_BLINK_EN
      nframes = 61;
`else
      nframes = 4;
`endif
      for (int f = 0; f < nframes; f++) begin
         step(3);
`ifdef TEXT_BLINK_EN
         e = (f >= 30 && f < 60) ? WHT : BG;
`else
         e = WHT;
`endif
         check($sformatf("blink_f%0d", f), rgb, e);
         vsync_in = 1'b0;
         step(1);
         vsync_in = 1'b1;
         step(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
